// File: rtl/if_id_hazard_ctrl.sv
// rtl/if_id_hazard_ctrl.sv - IF/ID hazard, stall, flush and fetch-wait sequencing (optional HAZ_PERF_EN counters)
module if_id_hazard_ctrl #(
    parameter int LOAD_BR_STALLS = 2,
    parameter int WAIT_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dest,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        imem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        fetch_err
`ifdef HAZ_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] LB_LEN  = 2'(LOAD_BR_STALLS);
    localparam logic [7:0] WAIT_TO = 8'(WAIT_TIMEOUT);

    state_t     state, state_d;
    logic [1:0] cnt, cnt_d;
    logic [7:0] wcnt, wcnt_d;
    logic       ferr_d;

    logic       uses_rs, uses_rt, is_br;
    logic       ex_match, mem_match;
    logic [1:0] haz_len;
    logic       stall;

    always_comb begin
        uses_rs   = !(id_opcode inside {6'h02, 6'h03, 6'h0F});
        uses_rt   = id_opcode inside {6'h00, 6'h04, 6'h05, 6'h2B};
        is_br     = id_opcode inside {6'h04, 6'h05};
        ex_match  = (ex_dest != 5'd0) &&
                    ((uses_rs && id_rs == ex_dest) || (uses_rt && id_rt == ex_dest));
        mem_match = (mem_dest != 5'd0) &&
                    ((uses_rs && id_rs == mem_dest) || (uses_rt && id_rt == mem_dest));
    end

    // Longest of the applicable hazards; the load-branch case is never shorter than 1.
    always_comb begin
        haz_len = 2'd0;
        if (!is_br && ex_mem_read && ex_match)
            haz_len = 2'd1;
        if (is_br && mem_mem_read && mem_match)
            haz_len = 2'd1;
        if (is_br && ex_reg_write && ex_match)
            haz_len = ex_mem_read ? LB_LEN : 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= 2'd0;
            wcnt      <= 8'd0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            wcnt      <= wcnt_d;
            fetch_err <= ferr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wcnt_d  = wcnt;
        ferr_d  = fetch_err;
        case (state)
            RUN: begin
                if (haz_len != 2'd0) begin
                    if (haz_len > 2'd1) begin
                        state_d = STALL;
                        cnt_d   = haz_len - 2'd1;
                    end
                end else if (!imem_ready) begin
                    state_d = WAIT;
                    wcnt_d  = 8'd1;
                    if (WAIT_TO == 8'd1)
                        ferr_d = 1'b1;
                end
            end
            STALL: begin
                if (cnt <= 2'd1) begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d   = cnt - 2'd1;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    state_d = RUN;
                    wcnt_d  = 8'd0;
                end else begin
                    if (wcnt < WAIT_TO)
                        wcnt_d = wcnt + 8'd1;
                    if (wcnt_d == WAIT_TO)
                        ferr_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
                wcnt_d  = 8'd0;
            end
        endcase
    end

    // A redirect seen while stalled is simply held; the branch stays in ID until RUN.
    always_comb begin
        case (state)
            RUN:     stall = (haz_len != 2'd0) || !imem_ready;
            STALL:   stall = 1'b1;
            WAIT:    stall = !imem_ready;
            default: stall = 1'b0;
        endcase
        pc_write     = !stall;
        if_id_write  = !stall;
        id_ex_bubble = stall;
        if_id_flush  = !stall && (branch_taken || jump);
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (id_ex_bubble && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (if_id_flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// tb/tb_if_id_hazard_ctrl.sv - scoreboard bench for if_id_hazard_ctrl
module tb_if_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  id_opcode = 6'd0;
    logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, ex_dest = 5'd0, mem_dest = 5'd0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, mem_mem_read = 1'b0;
    logic        branch_taken = 1'b0, jump = 1'b0, imem_ready = 1'b1;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, fetch_err;
`ifdef HAZ_PERF_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int tests = 0;
    int fails = 0;
    logic exp_ferr = 1'b0;
    logic [4:0] exp_q[$];
    string      name_q[$];

    if_id_hazard_ctrl #(.LOAD_BR_STALLS(2), .WAIT_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
        .branch_taken(branch_taken), .jump(jump), .imem_ready(imem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fetch_err(fetch_err)
`ifdef HAZ_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    // Expected word: {pc_write, if_id_write, if_id_flush, id_ex_bubble, fetch_err}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [4:0] exp;
            logic [4:0] act;
            string nm;
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, fetch_err};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b", nm, act, exp);
            end
        end
    end

    task automatic cyc(input string nm, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic exrw, input logic exmr, input logic [4:0] exd,
                       input logic memmr, input logic [4:0] memd,
                       input logic bt, input logic j, input logic imr, input logic [3:0] ctl);
        @(posedge clk);
        #1;
        reset = 1'b0;
        id_opcode = op; id_rs = rs; id_rt = rt;
        ex_reg_write = exrw; ex_mem_read = exmr; ex_dest = exd;
        mem_mem_read = memmr; mem_dest = memd;
        branch_taken = bt; jump = j; imem_ready = imr;
        exp_q.push_back({ctl, exp_ferr});
        name_q.push_back(nm);
    endtask

    task automatic rst_cycle(input string nm);
        @(posedge clk);
        #1;
        reset = 1'b1;
        id_opcode = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dest = 5'd0;
        mem_mem_read = 1'b0; mem_dest = 5'd0;
        branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b1;
        exp_ferr = 1'b0;
        exp_q.push_back({4'b1100, 1'b0});
        name_q.push_back(nm);
    endtask

    localparam logic [3:0] NORM = 4'b1100;
    localparam logic [3:0] FLSH = 4'b1110;
    localparam logic [3:0] STAL = 4'b0001;

    initial begin
        rst_cycle("reset_state");
        cyc("idle",           6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        // load-use: one stall, then lw has moved to MEM
        cyc("lu_stall",       6'h00, 5'd5, 5'd6, 1, 1, 5'd5, 0, 5'd0, 0, 0, 1, STAL);
        cyc("lu_release",     6'h00, 5'd5, 5'd6, 0, 0, 5'd0, 1, 5'd5, 0, 0, 1, NORM);
        // branch after load: two stalls, redirect held, then flush
        cyc("lb_stall1",      6'h04, 5'd5, 5'd7, 1, 1, 5'd5, 0, 5'd0, 1, 0, 1, STAL);
        cyc("lb_stall2",      6'h04, 5'd5, 5'd7, 0, 0, 5'd0, 1, 5'd5, 1, 0, 1, STAL);
        cyc("lb_redirect",    6'h04, 5'd5, 5'd7, 0, 0, 5'd0, 0, 5'd0, 1, 0, 1, FLSH);
        cyc("lb_after",       6'h00, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        // branch on ALU result in EX, then on load in MEM: one stall each
        cyc("br_alu_stall",   6'h05, 5'd1, 5'd9, 1, 0, 5'd9, 0, 5'd0, 0, 0, 1, STAL);
        cyc("br_alu_release", 6'h05, 5'd1, 5'd9, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        cyc("br_mem_stall",   6'h04, 5'd3, 5'd4, 0, 0, 5'd0, 1, 5'd3, 0, 0, 1, STAL);
        cyc("br_mem_release", 6'h04, 5'd3, 5'd4, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        // no-hazard boundaries
        cyc("alu_fwd",        6'h00, 5'd4, 5'd0, 1, 0, 5'd4, 0, 5'd0, 0, 0, 1, NORM);
        cyc("dest_zero",      6'h00, 5'd0, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        cyc("jal_no_rs",      6'h03, 5'd8, 5'd0, 1, 1, 5'd8, 0, 5'd0, 0, 1, 1, FLSH);
        cyc("lui_no_rs",      6'h0F, 5'd8, 5'd0, 1, 1, 5'd8, 0, 5'd0, 0, 0, 1, NORM);
        cyc("sw_rt_stall",    6'h2B, 5'd1, 5'd8, 1, 1, 5'd8, 0, 5'd0, 0, 0, 1, STAL);
        cyc("sw_release",     6'h2B, 5'd1, 5'd8, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        cyc("addi_no_rt",     6'h08, 5'd1, 5'd8, 1, 1, 5'd8, 0, 5'd0, 0, 0, 1, NORM);
        cyc("redirect_only",  6'h04, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 1, 0, 1, FLSH);
        // hazard outranks imem not ready; single-cycle hazard stays in RUN
        cyc("haz_over_imem",  6'h00, 5'd5, 5'd0, 1, 1, 5'd5, 0, 5'd0, 0, 0, 0, STAL);
        cyc("haz_imem_after", 6'h00, 5'd5, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        // short imem wait; on resume hazards are not rechecked, redirect serviced
        cyc("wait1",          6'h04, 5'd2, 5'd3, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0, STAL);
        cyc("wait2",          6'h04, 5'd2, 5'd3, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0, STAL);
        cyc("wait_resume",    6'h04, 5'd2, 5'd3, 1, 1, 5'd2, 0, 5'd0, 1, 0, 1, FLSH);
        // maximum of two branch hazards: two stalls
        cyc("max_stall1",     6'h04, 5'd5, 5'd6, 1, 1, 5'd5, 1, 5'd6, 0, 0, 1, STAL);
        cyc("max_stall2",     6'h04, 5'd5, 5'd6, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, STAL);
        cyc("max_release",    6'h04, 5'd5, 5'd6, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        // reset in the middle of a STALL
        cyc("pre_rst_stall",  6'h04, 5'd5, 5'd6, 1, 1, 5'd5, 0, 5'd0, 0, 0, 1, STAL);
        rst_cycle("rst_mid_stall");
        cyc("post_rst_run",   6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        // long imem stall: fetch_err set after the 255th not-ready cycle
        rst_cycle("rst_before_to");
        for (int i = 1; i <= 300; i++) begin
            if (i >= 256) exp_ferr = 1'b1;
            cyc("wait_timeout", 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, STAL);
        end
        cyc("err_sticky1",    6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
`ifdef HAZ_PERF_EN
        @(negedge clk);
        tests++;
        if (stall_cycles !== 16'd300) begin
            fails++;
            $display("FAIL stall_cycles: got %0d expected 300", stall_cycles);
        end
`endif
        cyc("err_sticky2",    6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);
        rst_cycle("rst_clears_err");
        cyc("final_idle",     6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, NORM);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
